// File: rtl/uart_fifo_sequencer.sv
// Read-side sequencer: pops bytes from the LFSR FIFO and hands them one UART frame at a time.
// Define UART_SEQ_DELIM_EN to append an 8'h0A delimiter after every BYTES_PER_WORD data bytes.
module uart_fifo_sequencer #(
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned BYTES_PER_WORD = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_50,
  input  logic        clr,
  input  logic        run,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_q,
  output logic        rdreq,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        wr_en,
  output logic        active,
  output logic [3:0]  byte_idx,
  output logic [15:0] sent_cnt,
  output logic        err_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + RD_LATENCY) + 1;
  localparam logic [CntW-1:0] LatLast = CntW'(RD_LATENCY - 1);
  // Counting starts in the cycle after the strobe, so the last waiting cycle is TIMEOUT_CYCLES-2.
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]      IdxLast = 4'(BYTES_PER_WORD - 1);
  localparam logic [7:0]      DelimByte = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StWaitQ,
    StLoad,
    StWaitBusy,
    StWaitDone
`ifdef UART_SEQ_DELIM_EN
    ,
    StDelim
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic [15:0]     sent_cnt_q, sent_cnt_d;
  logic            err_q, err_d;
  logic            rdreq_q, rdreq_d;
  logic            wr_en_q, wr_en_d;
  logic            active_q, active_d;
  logic            timeout;
`ifdef UART_SEQ_DELIM_EN
  logic            delim_pend_q, delim_pend_d;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk_50) begin
    if (clr) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      byte_idx_q <= '0;
      sent_cnt_q <= '0;
      err_q      <= 1'b0;
      rdreq_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      active_q   <= 1'b0;
`ifdef UART_SEQ_DELIM_EN
      delim_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      byte_idx_q <= byte_idx_d;
      sent_cnt_q <= sent_cnt_d;
      err_q      <= err_d;
      rdreq_q    <= rdreq_d;
      wr_en_q    <= wr_en_d;
      active_q   <= active_d;
`ifdef UART_SEQ_DELIM_EN
      delim_pend_q <= delim_pend_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      StIdle: begin
        if (run && !fifo_empty && !tx_busy) begin
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StWaitQ;
      end
      StWaitQ: begin
        if (cnt_q == LatLast) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == TmoLast) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
`ifdef UART_SEQ_DELIM_EN
          state_d = delim_pend_q ? StDelim : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef UART_SEQ_DELIM_EN
      StDelim: begin
        state_d = StWaitBusy;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output and datapath next values; every output is taken from a flop.
  always_comb begin
    cnt_d      = (state_d == state_q) ? cnt_q + CntW'(1) : '0;
    tx_data_d  = tx_data_q;
    byte_idx_d = byte_idx_q;
    sent_cnt_d = sent_cnt_q;
    err_d      = err_q | timeout;

    if ((state_q == StWaitQ) && (cnt_q == LatLast)) begin
      tx_data_d = fifo_q;
    end

    if (state_q == StLoad) begin
      sent_cnt_d = sent_cnt_q + 16'd1;
      byte_idx_d = (byte_idx_q == IdxLast) ? 4'd0 : byte_idx_q + 4'd1;
    end

    rdreq_d  = (state_d == StPop);
    wr_en_d  = (state_d == StLoad);
    active_d = (state_d != StIdle);

`ifdef UART_SEQ_DELIM_EN
    delim_pend_d = delim_pend_q;
    if ((state_q == StLoad) && (byte_idx_q == IdxLast)) begin
      delim_pend_d = 1'b1;
    end
    // A timed-out frame abandons its pending delimiter along with the byte.
    if ((state_q == StDelim) || timeout) begin
      delim_pend_d = 1'b0;
    end
    if (state_d == StDelim) begin
      tx_data_d = DelimByte;
      wr_en_d   = 1'b1;
    end
`endif
  end

  assign rdreq       = rdreq_q;
  assign wr_en       = wr_en_q;
  assign active      = active_q;
  assign tx_data     = tx_data_q;
  assign byte_idx    = byte_idx_q;
  assign sent_cnt    = sent_cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_fifo_sequencer.sv
// Directed bench for uart_fifo_sequencer with behavioural FIFO and transmitter models.
// Build with UART_SEQ_DELIM_EN defined to also check the word delimiter.
module tb_uart_fifo_sequencer;

`ifdef UART_SEQ_DELIM_EN
  localparam int WordPulses = 9;
`else
  localparam int WordPulses = 8;
`endif

  logic        clk_50 = 1'b0;
  logic        clr;
  logic        run;
  logic        fifo_empty;
  logic [7:0]  fifo_q = 8'h00;
  logic        rdreq;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic        active;
  logic [3:0]  byte_idx;
  logic [15:0] sent_cnt;
  logic        err_timeout;

  int cyc = 0;
  int npass = 0;
  int nfail = 0;
  int ntotal = 0;
  int rdreq_cnt = 0;
  int wr_cnt = 0;
  int bad_empty = 0;
  int bad_overlap = 0;
  int busy_len = 20;
  int busy_cnt = 0;
  int rd_ptr = 0;
  int wr_ptr = 0;
  logic [7:0] mem  [64];
  logic [7:0] wlog [64];

  always #10 clk_50 = ~clk_50;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign tx_busy    = (busy_cnt != 0);

  uart_fifo_sequencer #(
    .RD_LATENCY    (1),
    .BYTES_PER_WORD(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_50     (clk_50),
    .clr        (clr),
    .run        (run),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .rdreq      (rdreq),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .wr_en      (wr_en),
    .active     (active),
    .byte_idx   (byte_idx),
    .sent_cnt   (sent_cnt),
    .err_timeout(err_timeout)
  );

  // FIFO (latency 1) and transmitter models plus protocol monitors.
  always @(posedge clk_50) begin
    cyc <= cyc + 1;
    if (rdreq === 1'b1) begin
      rdreq_cnt <= rdreq_cnt + 1;
      fifo_q    <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
      if (fifo_empty) bad_empty <= bad_empty + 1;
    end
    if (wr_en === 1'b1) begin
      wlog[wr_cnt[5:0]] <= tx_data;
      wr_cnt <= wr_cnt + 1;
      if (busy_len > 0) busy_cnt <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (rdreq === 1'b1 && wr_en === 1'b1) bad_overlap <= bad_overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // sel: 0 rdreq=1, 1 wr_en=1, 2 tx_busy=0, 3 active=0, 4 tx_busy=1
  function automatic logic cond(input int sel);
    case (sel)
      0:       return rdreq === 1'b1;
      1:       return wr_en === 1'b1;
      2:       return tx_busy === 1'b0;
      3:       return active === 1'b0;
      default: return tx_busy === 1'b1;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel, input int limit);
    int n = 0;
    while (!cond(sel) && n < limit) begin
      @(negedge clk_50);
      n++;
    end
    check(tag, 32'(cond(sel)), 32'd1);
  endtask

  task automatic wait_wrcnt(input string tag, input int target, input int limit);
    int n = 0;
    while (wr_cnt < target && n < limit) begin
      @(negedge clk_50);
      n++;
    end
    check(tag, 32'(wr_cnt), 32'(target));
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rdreq"}, 32'(rdreq), 32'd0);
    check({pfx, "_wr_en"}, 32'(wr_en), 32'd0);
    check({pfx, "_active"}, 32'(active), 32'd0);
    check({pfx, "_tx_data"}, 32'(tx_data), 32'd0);
    check({pfx, "_byte_idx"}, 32'(byte_idx), 32'd0);
    check({pfx, "_sent_cnt"}, 32'(sent_cnt), 32'd0);
    check({pfx, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tf;
    int base;
    int r0;

    // Reset from power-up, then idle with an empty FIFO.
    clr = 1'b1;
    run = 1'b1;
    repeat (2) @(negedge clk_50);
    check_all_zero("reset");
    clr = 1'b0;
    r0 = rdreq_cnt;
    repeat (100) @(negedge clk_50);
    check("empty_no_rdreq", 32'(rdreq_cnt - r0), 32'd0);
    check("empty_idle", 32'(active), 32'd0);

    // Single byte with a 20-cycle busy span.
    busy_len = 20;
    push(8'hA5);
    wait_until("pop1_seen", 0, 10);
    t = cyc;
    check("pop1_active", 32'(active), 32'd1);
    @(negedge clk_50);
    check("waitq_no_wr", 32'(wr_en), 32'd0);
    check("waitq_no_rdreq", 32'(rdreq), 32'd0);
    @(negedge clk_50);
    check("load_wr_en", 32'(wr_en), 32'd1);
    check("load_data", 32'(tx_data), 32'hA5);
    check("load_latency", 32'(cyc - t), 32'd2);
    @(negedge clk_50);
    check("load_single", 32'(wr_en), 32'd0);
    check("hold_data", 32'(tx_data), 32'hA5);
    push(8'h3C);
    wait_until("busy1_fall", 2, 60);
    tf = cyc;
    check("frame1_cnt", 32'(sent_cnt), 32'd1);
    check("frame1_idx", 32'(byte_idx), 32'd1);
    wait_until("pop2_seen", 0, 20);
    check("pop2_gap", 32'(cyc - tf), 32'd2);
    wait_until("frame2_idle", 3, 100);
    check("frame2_data", 32'(wlog[1]), 32'h3C);
    check("frame2_cnt", 32'(sent_cnt), 32'd2);
    check("frame2_idx", 32'(byte_idx), 32'd2);

    // Transmitter never goes busy: sticky timeout 16 cycles after the strobe.
    busy_len = 0;
    push(8'h5A);
    wait_until("tmo_wr_seen", 1, 20);
    repeat (15) @(negedge clk_50);
    check("tmo_early", 32'(err_timeout), 32'd0);
    @(negedge clk_50);
    check("tmo_set", 32'(err_timeout), 32'd1);
    check("tmo_idle", 32'(active), 32'd0);
    repeat (20) @(negedge clk_50);
    check("tmo_sticky", 32'(err_timeout), 32'd1);
    check("tmo_counted", 32'(sent_cnt), 32'd3);

    // Reset while waiting for busy.
    push(8'h66);
    wait_until("mid_wr_seen", 1, 20);
    repeat (3) @(negedge clk_50);
    check("mid_active", 32'(active), 32'd1);
    clr = 1'b1;
    @(negedge clk_50);
    check_all_zero("midclr");
    clr = 1'b0;

    // Full word of eight bytes.
    busy_len = 5;
    base = wr_cnt;
    for (int b = 1; b <= 8; b++) push(8'(b));
    wait_wrcnt("word_pulses", base + WordPulses, 400);
    wait_until("word_idle", 3, 100);
    for (int i = 0; i < 8; i++) check("word_data", 32'(wlog[(base + i) % 64]), 32'(i + 1));
`ifdef UART_SEQ_DELIM_EN
    check("word_delim", 32'(wlog[(base + 8) % 64]), 32'h0A);
`endif
    check("word_cnt", 32'(sent_cnt), 32'd8);
    check("word_idx", 32'(byte_idx), 32'd0);

    // Drop run during WAIT_DONE of the third byte.
    busy_len = 10;
    base = wr_cnt;
    r0 = rdreq_cnt;
    for (int b = 0; b < 5; b++) push(8'h11 + 8'(b));
    wait_wrcnt("drop_three", base + 3, 200);
    wait_until("drop_busy", 4, 5);
    @(negedge clk_50);
    run = 1'b0;
    repeat (60) @(negedge clk_50);
    check("drop_rdreq", 32'(rdreq_cnt - r0), 32'd3);
    check("drop_idle", 32'(active), 32'd0);
    check("drop_cnt", 32'(sent_cnt), 32'd11);
    check("drop_idx", 32'(byte_idx), 32'd3);
    check("drop_data3", 32'(wlog[(base + 2) % 64]), 32'h13);

    // Counter wrap: preload 0xFFFF, resume with the two remaining bytes.
    force dut.sent_cnt_q = 16'hFFFF;
    @(negedge clk_50);
    release dut.sent_cnt_q;
    @(negedge clk_50);
    check("wrap_preload", 32'(sent_cnt), 32'hFFFF);
    run = 1'b1;
    wait_until("wrap_wr_seen", 1, 20);
    @(negedge clk_50);
    check("wrap_zero", 32'(sent_cnt), 32'd0);
    wait_wrcnt("wrap_pulses", base + 5, 200);
    wait_until("wrap_idle", 3, 100);
    check("wrap_cnt", 32'(sent_cnt), 32'd1);
    check("wrap_idx", 32'(byte_idx), 32'd5);
    check("wrap_data4", 32'(wlog[(base + 3) % 64]), 32'h14);
    check("wrap_data5", 32'(wlog[(base + 4) % 64]), 32'h15);

    check("no_rdreq_wr_overlap", 32'(bad_overlap), 32'd0);
    check("no_rdreq_when_empty", 32'(bad_empty), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/uart_fifo_sequencer.md
# uart_fifo_sequencer

Autonomous read-side controller between the dual-clock LFSR FIFO (8-bit read port) and the UART transmitter. It replaces the manually driven `Rdreq`/`Wr_en` pushbuttons. While enabled, it pops one byte at a time from the FIFO, presents it to the transmitter, and issues a single `wr_en` strobe. It then tracks `Tx_busy` through one complete frame before popping the next byte. It runs entirely in the `clk_50` domain; the FIFO read clock is tied to `clk_50` at integration.

## Interface
- `RD_LATENCY`, 1: cycles from the `rdreq` pulse to valid `fifo_q` (range 1–3).
- `BYTES_PER_WORD`, 8: data bytes per 64-bit LFSR word (range 1–15).
- `TIMEOUT_CYCLES`, 16: maximum cycles to wait for `tx_busy` to rise after `wr_en`.
- `clk_50` input 1: 50 MHz system clock; all logic on the rising edge.
- `clr` input 1: synchronous, active-high reset.
- `run` input 1: level enable for sequencing.
- `fifo_empty` input 1: FIFO `rdempty`.
- `fifo_q` input 8: FIFO read data.
- `rdreq` output 1: FIFO read request, one-cycle pulse.
- `tx_busy` input 1: transmitter `Tx_busy`.
- `tx_data` output 8: registered byte to transmitter `data_in`.
- `wr_en` output 1: transmitter start strobe, one-cycle pulse.
- `active` output 1: high whenever the FSM is not in IDLE.
- `byte_idx` output 4: position of the current byte within the word, 0..BYTES_PER_WORD-1.
- `sent_cnt` output 16: data bytes handed to the transmitter; wraps at 0xFFFF→0.
- `err_timeout` output 1: sticky error flag, cleared only by `clr`.

## Operation
FSM states: IDLE, POP, WAIT_Q, LOAD, WAIT_BUSY, WAIT_DONE, DELIM (the last exists only when the macro is defined).

- **IDLE → POP** when `run && !fifo_empty && !tx_busy`. Otherwise the FSM stays in IDLE.
- **POP:** `rdreq`=1 for exactly this one cycle, then go to WAIT_Q.
- **WAIT_Q:** hold for RD_LATENCY cycles. On the last of these cycles, `tx_data` <= `fifo_q`. Then go to LOAD.
- **LOAD:** `wr_en`=1 for one cycle with `tx_data` stable, then go to WAIT_BUSY. In this cycle `sent_cnt` increments by 1 (wrapping) and `byte_idx` advances. `byte_idx` returns to 0 after BYTES_PER_WORD-1.
- **WAIT_BUSY:** wait for `tx_busy`=1, then go to WAIT_DONE.
  - If `tx_busy` is not seen within TIMEOUT_CYCLES cycles, set `err_timeout`=1 and return to IDLE. The byte is counted but may have been lost.
- **WAIT_DONE:** wait for `tx_busy`=0.
  - Go to DELIM if the macro is enabled and `byte_idx` wrapped to 0 in this frame.
  - Otherwise go to IDLE; from IDLE the next pop may start on the following cycle.
- **`run` deasserted mid-frame:** the current byte completes through WAIT_DONE (and DELIM if pending), then the FSM parks in IDLE. No further `rdreq` is issued.
- **`fifo_empty`:** sampled only in IDLE. `rdreq` is never asserted while `fifo_empty`=1.
- **`clr` at any state:** on the next edge, state=IDLE and all outputs are 0. `tx_data`, `sent_cnt`, `byte_idx` and `err_timeout` all reset to 0. A byte in flight is discarded.
- **Simultaneous `clr` and `run`:** `clr` wins.
- `rdreq` and `wr_en` are never high in the same cycle.

## Timing
- **Reset values:** `rdreq`=0, `wr_en`=0, `active`=0, `tx_data`=8'h00, `byte_idx`=0, `sent_cnt`=0, `err_timeout`=0.
- **Pop at cycle T:** `tx_data` is captured at the end of cycle T+RD_LATENCY, and `wr_en` is high in cycle T+RD_LATENCY+1.
- **Minimum byte-to-byte spacing** = 1 (IDLE) + 1 (POP) + RD_LATENCY + 1 (LOAD) + transmitter busy span + 1 (WAIT_DONE exit).
- **`active`:** registered; it rises in the POP cycle and falls on the cycle the FSM re-enters IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`UART_SEQ_DELIM_EN` defined:** after every BYTES_PER_WORD data bytes, the DELIM state loads `tx_data`=8'h0A and pulses `wr_en`. It then performs the same WAIT_BUSY/WAIT_DONE handling, including the timeout, and returns to IDLE.
  - The delimiter does not increment `sent_cnt` or `byte_idx`.
  - `rdreq` is not asserted during DELIM.
- **`UART_SEQ_DELIM_EN` undefined:** the DELIM state and its logic are absent. Bytes stream back-to-back with no delimiter.

## Test plan
- **Reset:** `clr`=1 for 2 cycles from a random state → all outputs 0. Then, with `run`=1 and `fifo_empty`=1 for 100 cycles → `rdreq` is never asserted.
- **Single byte, RD_LATENCY=1:** FIFO model returns 8'hA5 and the transmitter model holds busy for 20 cycles. Required response:
  - `rdreq` at T, `tx_data`=8'hA5 from T+2, `wr_en` only at T+2.
  - `sent_cnt`=1, `byte_idx`=1.
  - The next `rdreq` comes no earlier than 2 cycles after busy falls.
- **Full word:** push 8 bytes 8'h01..8'h08 with `run`=1 → 8 `wr_en` pulses with data in order; `sent_cnt`=8, `byte_idx`=0.
  - With `UART_SEQ_DELIM_EN` defined: a 9th pulse with 8'h0A follows, and `sent_cnt` stays 8.
- **Run drop:** deassert `run` during WAIT_DONE of byte 3 → byte 3 finishes, the FSM parks in IDLE, and there is no 4th `rdreq`.
- **Timeout:** the transmitter model never asserts busy → `err_timeout`=1 exactly 16 cycles after `wr_en`; the FSM returns to IDLE and the flag stays set until `clr`.
- **Reset mid-frame and wrap:** assert `clr` in WAIT_BUSY → next cycle all outputs are 0. Separately, preload `sent_cnt`=0xFFFF via 65535 bytes (or force it) and send one byte → `sent_cnt`=0x0000.
